edge_det: RTL and testbench
===========================

// Module: edge_det
// PURPOSE
//   Registered rising/falling/dual edge detector for a WIDTH-bit level input.
//   Samples each bit of signal on every clk rising edge and emits a one-clock pulse per bit
//   when that bit changes between consecutive samples.
//   Sits at the boundary between level-type control/status lines and pulse-driven logic:
//   counters, interrupt latches, FSM triggers.
//   Optional input synchronizer makes it safe for asynchronous inputs.
// PARAMETERS
//   WIDTH        1  number of independent input bits; each bit has its own detector lane
//   SYNC_STAGES  0  flops in the input synchronizer (0 = bypass, signal already in clk domain;
//                   values 2..3 for async inputs)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   signal     in   WIDTH  level input(s) to monitor
//   Rise_Edge  out  WIDTH  1-cycle pulse per bit on 0->1 transition
//   Fall_Edge  out  WIDTH  1-cycle pulse per bit on 1->0 transition
//   Dual_Edge  out  WIDTH  1-cycle pulse per bit on any transition
// BEHAVIOUR
//   - Reset is synchronous and active-high on clk; polarity and synchronicity are fixed.
//   - While rst=1 at a clk rising edge: Rise_Edge, Fall_Edge, Dual_Edge <= 0.
//     History register and synchronizer flops <= 0; primed flag <= 0.
//   - Let s = synchronized signal (s = signal when SYNC_STAGES=0), prev = history register.
//   - Each clk rising edge with rst=0:
//       prev <= s; primed <= 1
//       if primed:  Rise <= s & ~prev; Fall <= ~s & prev; Dual <= s ^ prev
//       else:       Rise/Fall/Dual <= 0
//     The first post-reset sample only primes history: a level already high at reset release
//     produces no edge.
//   - All outputs are registered; none is combinational from signal.
//   - Latency: a change on signal that settles before clk rising edge N is reported during
//     cycle N..N+1, plus SYNC_STAGES additional cycles.
//   - Pulse width is exactly one clk cycle per transition.
//   - A level held steady for any number of cycles produces no further pulses.
//   - Dual_Edge == Rise_Edge | Fall_Edge at all times.
//   - Rise_Edge & Fall_Edge == 0 per bit at all times.
//   - Toggling every cycle gives a continuous pulse train:
//     Dual stays high; Rise and Fall alternate each cycle.
//   - Glitches shorter than a clock period that do not straddle a rising edge are not detected.
//     This is by design.
//   - Reset asserted mid-pulse: outputs clear on that same edge.
//     After reset release, one priming cycle passes before new edges are reported.
//   - Bits are fully independent; simultaneous edges on different bits all report in the
//     same cycle.
// STRUCTURE
//   - Shared package edge_det_pkg: only the default constants
//     (EDGE_DET_DEF_WIDTH=1, EDGE_DET_DEF_SYNC=0).
//   - One sub-module, edge_det_sync: a WIDTH x SYNC_STAGES flop chain with synchronous reset.
//     It is generate-bypassed when SYNC_STAGES=0.
//   - Top level: edge_det_sync, then history register, primed flag, and registered output
//     logic, generated per bit.
// TESTING (clk period 4 ns, rising edges at 2,6,10..; WIDTH=1, SYNC_STAGES=0 unless noted)
//   1. Reset hold:
//      rst=1 to t=5, signal=0 -> all outputs 0 through t=18; no pulse on the priming edge
//      at t=6.
//   2. Basic edges:
//      signal 0->1 at t=15 -> Rise=Dual=1 for t=18..22.
//      signal 1->0 at t=25 -> Fall=Dual=1 for t=26..30.
//   3. Held level:
//      signal 1 at t=35, rewritten 1 at t=45 -> single Rise pulse at t=38..42,
//      nothing at t=46..54.
//      signal 0 at t=55 and held -> one Fall pulse at t=58..62 only.
//   4. Level high at reset release:
//      signal=1 during rst, rst drops -> no Rise pulse.
//      A later 1->0 transition produces a Fall pulse.
//   5. Toggle each cycle for 8 cycles:
//      Dual high continuously; Rise/Fall alternate; Rise&Fall never both 1.
//   6. WIDTH=4, SYNC_STAGES=2:
//      signal 0000->1010 -> Rise=1010 exactly 2 cycles later than with SYNC_STAGES=0.
//      Assert rst mid-pulse -> outputs 0 on that edge.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Default parameter values shared by the edge detector and its users.
package edge_det_pkg;

    localparam int EDGE_DET_DEF_WIDTH = 1;
    localparam int EDGE_DET_DEF_SYNC  = 0;

endpackage : edge_det_pkg

// File: rtl/edge_det_sync.sv
// WIDTH-bit flop chain that brings asynchronous levels into the clk domain.
// Every flop clears on the synchronous reset, so the output reads zero
// until STAGES clean samples have propagated through.
module edge_det_sync
    import edge_det_pkg::*;
#(
    parameter int WIDTH  = EDGE_DET_DEF_WIDTH,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain_reg;

    // Shift the input down the chain one stage per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg <= '0;
        end else begin
            chain_reg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain_reg[i] <= chain_reg[i-1];
            end
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule : edge_det_sync

// File: rtl/edge_det.sv
// Registered per-bit rising / falling / any-edge pulse generator.
// Each bit compares the current sample against the previous one.
// The first sample after reset only loads history, so a level that is
// already high when reset releases does not produce an edge.
module edge_det
    import edge_det_pkg::*;
#(
    parameter int WIDTH       = EDGE_DET_DEF_WIDTH,
    parameter int SYNC_STAGES = EDGE_DET_DEF_SYNC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] signal,
    output logic [WIDTH-1:0] Rise_Edge,
    output logic [WIDTH-1:0] Fall_Edge,
    output logic [WIDTH-1:0] Dual_Edge
);

    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] rise_reg;
    logic [WIDTH-1:0] fall_reg;
    logic [WIDTH-1:0] dual_reg;
    logic             primed_reg;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            // The input is already in the clk domain.
            assign sample = signal;
        end else begin : g_sync
            edge_det_sync #(
                .WIDTH  (WIDTH),
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (signal),
                .q   (sample)
            );
        end
    endgenerate

    // Shared flag: set once the first post-reset sample has loaded history.
    always_ff @(posedge clk) begin
        if (rst) begin
            primed_reg <= 1'b0;
        end else begin
            primed_reg <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            // Per-bit history and registered edge pulses.
            always_ff @(posedge clk) begin
                if (rst) begin
                    prev_reg[gi] <= 1'b0;
                    rise_reg[gi] <= 1'b0;
                    fall_reg[gi] <= 1'b0;
                    dual_reg[gi] <= 1'b0;
                end else begin
                    prev_reg[gi] <= sample[gi];
                    if (primed_reg) begin
                        rise_reg[gi] <=  sample[gi] & ~prev_reg[gi];
                        fall_reg[gi] <= ~sample[gi] &  prev_reg[gi];
                        dual_reg[gi] <=  sample[gi] ^  prev_reg[gi];
                    end else begin
                        rise_reg[gi] <= 1'b0;
                        fall_reg[gi] <= 1'b0;
                        dual_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign Rise_Edge = rise_reg;
    assign Fall_Edge = fall_reg;
    assign Dual_Edge = dual_reg;

endmodule : edge_det

// File: tb/tb_edge_det.sv
// Bench for edge_det: a WIDTH=1/SYNC_STAGES=0 instance and a
// WIDTH=4/SYNC_STAGES=2 instance share one stimulus stream. A history-based
// model predicts both on every cycle, and directed literal checks pin it.
module tb_edge_det;

    logic       clk;
    logic       rst;
    logic [3:0] sig;

    logic       rise0, fall0, dual0;
    logic [3:0] rise1, fall1, dual1;

    int vectors;
    int miscompares;

    edge_det #(.WIDTH(1), .SYNC_STAGES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .signal    (sig[0]),
        .Rise_Edge (rise0),
        .Fall_Edge (fall0),
        .Dual_Edge (dual0)
    );

    edge_det #(.WIDTH(4), .SYNC_STAGES(2)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .signal    (sig),
        .Rise_Edge (rise1),
        .Fall_Edge (fall1),
        .Dual_Edge (dual1)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    // ---------------- behavioural model ----------------
    // hist[k] = raw input sampled at the k-th edge after reset release.
    // The value the detector sees at edge n is hist[n-S] (zero before that),
    // and edges are reported from the second post-reset edge on.
    logic [3:0] hist [0:4095];
    int         n_since;
    logic       model_valid;
    logic [3:0] exp_rise0, exp_fall0, exp_dual0;
    logic [3:0] exp_rise1, exp_fall1, exp_dual1;

    function automatic logic [3:0] seen(input int stages, input int n);
        if (n < 0 || n < stages) return 4'b0000;
        return hist[n - stages];
    endfunction

    always @(posedge clk) begin
        logic [3:0] c, p;
        if (rst) begin
            n_since   = 0;
            exp_rise0 = '0; exp_fall0 = '0; exp_dual0 = '0;
            exp_rise1 = '0; exp_fall1 = '0; exp_dual1 = '0;
        end else begin
            hist[n_since] = sig;
            if (n_since == 0) begin
                exp_rise0 = '0; exp_fall0 = '0; exp_dual0 = '0;
                exp_rise1 = '0; exp_fall1 = '0; exp_dual1 = '0;
            end else begin
                c = seen(0, n_since); p = seen(0, n_since - 1);
                exp_rise0 = c & ~p; exp_fall0 = ~c & p; exp_dual0 = c ^ p;
                c = seen(2, n_since); p = seen(2, n_since - 1);
                exp_rise1 = c & ~p; exp_fall1 = ~c & p; exp_dual1 = c ^ p;
            end
            n_since = n_since + 1;
        end
        model_valid = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            vectors = vectors + 1;
            if ({rise0, fall0, dual0} !== {exp_rise0[0], exp_fall0[0], exp_dual0[0]}) begin
                miscompares = miscompares + 1;
                $display("FAIL model_w1 t=%0t rise/fall/dual got %b%b%b expected %b%b%b",
                         $time, rise0, fall0, dual0, exp_rise0[0], exp_fall0[0], exp_dual0[0]);
            end
            vectors = vectors + 1;
            if ({rise1, fall1, dual1} !== {exp_rise1, exp_fall1, exp_dual1}) begin
                miscompares = miscompares + 1;
                $display("FAIL model_w4 t=%0t rise=%b fall=%b dual=%b expected rise=%b fall=%b dual=%b",
                         $time, rise1, fall1, dual1, exp_rise1, exp_fall1, exp_dual1);
            end
            vectors = vectors + 1;
            if ((dual1 !== (rise1 | fall1)) || ((rise1 & fall1) !== 4'b0000)) begin
                miscompares = miscompares + 1;
                $display("FAIL invariant_w4 t=%0t rise=%b fall=%b dual=%b expected dual=rise|fall, rise&fall=0",
                         $time, rise1, fall1, dual1);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check0(input string name, input logic [2:0] rfd_exp);
        check({name, "_rfd"}, {1'b0, rise0, fall0, dual0}, {1'b0, rfd_exp});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_valid = 1'b0;
        rst = 1'b1;
        sig = 4'b0000;

        // 1. reset hold, priming edge produces nothing
        tick();
        check0("reset", 3'b000);
        rst = 1'b0;
        tick();
        check0("priming", 3'b000);
        tick();
        check0("idle", 3'b000);

        // 2. basic rise then fall
        sig = 4'b0001;
        tick();
        check0("rise", 3'b101);
        tick();
        check0("rise_one_cycle", 3'b000);
        sig = 4'b0000;
        tick();
        check0("fall", 3'b011);

        // 3. held level: one pulse only
        sig = 4'b0001;
        tick();
        check0("held_rise", 3'b101);
        for (int i = 0; i < 4; i++) begin
            sig = 4'b0001;
            tick();
            check0("held_high", 3'b000);
        end
        sig = 4'b0000;
        tick();
        check0("held_fall", 3'b011);
        for (int i = 0; i < 3; i++) begin
            tick();
            check0("held_low", 3'b000);
        end

        // 4. level high across reset release
        sig = 4'b0001;
        rst = 1'b1;
        tick();
        tick();
        check0("rst_high_level", 3'b000);
        rst = 1'b0;
        tick();
        check0("release_prime", 3'b000);
        tick();
        check0("release_no_rise", 3'b000);
        sig = 4'b0000;
        tick();
        check0("release_fall", 3'b011);

        // 5. toggle each cycle
        tick();
        for (int i = 0; i < 8; i++) begin
            sig = {3'b000, ~sig[0]};
            tick();
            check0("toggle", {sig[0], ~sig[0], 1'b1});
        end

        // 6. four-bit lanes through a two-stage synchronizer
        sig = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        sig = 4'b1010;
        tick();
        check("w4_edge1", rise1, 4'b0000);
        tick();
        check("w4_edge2", rise1, 4'b0000);
        tick();
        check("w4_rise_late", rise1, 4'b1010);
        check("w4_dual_late", dual1, 4'b1010);
        tick();
        check("w4_rise_clear", rise1, 4'b0000);
        sig = 4'b0101;
        tick();
        tick();
        rst = 1'b1;   // pulse for 1010->0101 would appear on this edge
        tick();
        check("w4_rst_rise", rise1, 4'b0000);
        check("w4_rst_fall", fall1, 4'b0000);
        check("w4_rst_dual", dual1, 4'b0000);
        rst = 1'b0;

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) != 0) sig = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_edge_det
